// File: rtl/gpu_rect_addr_gen.sv
// Rectangle address generator: walks a w x h rectangle in raster order and
// emits the linear framebuffer address y*STRIDE + x for each pixel, with a
// valid/ready handshake. The start row offset y0*STRIDE is produced by an
// LSB-first shift-add multiplier; later rows add STRIDE incrementally.
module gpu_rect_addr_gen #(
    parameter int X_BITS    = 9,
    parameter int Y_BITS    = 8,
    parameter int STRIDE    = 320,
    parameter int ADDR_BITS = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [X_BITS-1:0]    x0,
    input  logic [Y_BITS-1:0]    y0,
    input  logic [X_BITS-1:0]    w,
    input  logic [Y_BITS-1:0]    h,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [X_BITS-1:0]    out_x,
    output logic [Y_BITS-1:0]    out_y,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_BITS = $clog2(Y_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SCAN,
        S_FIN
    } state_t;

    state_t               state_q;
    logic [X_BITS-1:0]    x0_q, w_q, col_q;
    logic [Y_BITS-1:0]    y0_q, h_q, row_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [ADDR_BITS-1:0] acc_q, mcand_q;
    logic [Y_BITS-1:0]    mplier_q;
    logic [CNT_BITS-1:0]  cnt_q;

    logic                 out_valid_q, out_last_q;
    logic [ADDR_BITS-1:0] out_addr_q;
    logic [X_BITS-1:0]    out_x_q;
    logic [Y_BITS-1:0]    out_y_q;

    logic [X_BITS-1:0]    w_m1, col_d, x_d;
    logic [Y_BITS-1:0]    h_m1, row_d, y_d;
    logic [ADDR_BITS-1:0] base_d, addr_d, acc_d;
    logic                 last_d;

    // Beat to present next: the current position while priming the output
    // registers, otherwise the raster successor of the beat being shown.
    always_comb begin
        w_m1   = w_q - X_BITS'(1);
        h_m1   = h_q - Y_BITS'(1);
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        if (out_valid_q) begin
            if (col_q < w_m1) begin
                col_d = col_q + X_BITS'(1);
            end else begin
                col_d  = '0;
                row_d  = row_q + Y_BITS'(1);
                base_d = base_q + ADDR_BITS'(STRIDE);
            end
        end
        addr_d = base_d + ADDR_BITS'(x0_q) + ADDR_BITS'(col_d);
        x_d    = x0_q + col_d;
        y_d    = y0_q + row_d;
        last_d = (col_d == w_m1) && (row_d == h_m1);
        acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Command FSM, multiplier datapath, raster counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            base_q      <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x0_q     <= x0;
                        y0_q     <= y0;
                        w_q      <= w;
                        h_q      <= h;
                        acc_q    <= '0;
                        mcand_q  <= ADDR_BITS'(STRIDE);
                        mplier_q <= y0;
                        cnt_q    <= '0;
                        state_q  <= (w == '0 || h == '0) ? S_FIN : S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CNT_BITS'(Y_BITS - 1)) begin
                        base_q  <= acc_d;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= S_SCAN;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_BITS'(1);
                    end
                end
                S_SCAN: begin
                    // First SCAN cycle loads the output registers; after that
                    // they only move on a completed transfer.
                    if (!out_valid_q || out_ready) begin
                        if (out_valid_q && out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_FIN;
                        end else begin
                            col_q       <= col_d;
                            row_q       <= row_d;
                            base_q      <= base_d;
                            out_valid_q <= 1'b1;
                            out_addr_q  <= addr_d;
                            out_x_q     <= x_d;
                            out_y_q     <= y_d;
                            out_last_q  <= last_d;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_gpu_rect_addr_gen.sv
// Directed, table-driven bench for gpu_rect_addr_gen.
module tb_gpu_rect_addr_gen;

    localparam int X_BITS    = 9;
    localparam int Y_BITS    = 8;
    localparam int STRIDE    = 320;
    localparam int ADDR_BITS = 17;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [X_BITS-1:0]    x0, w;
    logic [Y_BITS-1:0]    y0, h;
    logic                 out_ready;
    logic                 out_valid;
    logic [ADDR_BITS-1:0] out_addr;
    logic [X_BITS-1:0]    out_x;
    logic [Y_BITS-1:0]    out_y;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    gpu_rect_addr_gen #(
        .X_BITS   (X_BITS),
        .Y_BITS   (Y_BITS),
        .STRIDE   (STRIDE),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_addr (out_addr),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        int beats;       // expected number of beats
        int first_addr;  // hand-computed address of the first beat
        int final_addr;  // hand-computed address of the last beat
        int mode;        // 0: ready always 1, 1: 1,0,0,1 pattern, 2: random
        bit inject;      // issue a second start mid-SCAN
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_addr"},  32'(out_addr),  32'd0);
        chk({tag, "_x"},     32'(out_x),     32'd0);
        chk({tag, "_y"},     32'(out_y),     32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    task automatic run_cmd(input vec_t v);
        int lat;
        int idx;
        int p;
        int guard;
        int col, row;
        bit xfer;
        bit injected;
        @(negedge clk);
        x0 = X_BITS'(v.x0);
        y0 = Y_BITS'(v.y0);
        w  = X_BITS'(v.w);
        h  = Y_BITS'(v.h);
        start = 1'b1;
        out_ready = (v.mode != 1) ? 1'b1 : 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (v.beats == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("zero_done_fall", 32'(done), 32'd0);
            chk("zero_busy_fall", 32'(busy), 32'd0);
            chk("zero_valid_after", 32'(out_valid), 32'd0);
            return;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(Y_BITS + 1));
        idx = 0;
        p = 0;
        guard = 0;
        injected = 1'b0;
        while (idx < v.beats && guard < 20 * v.beats + 40) begin
            col = idx % v.w;
            row = idx / v.w;
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_addr", 32'(out_addr),
                32'(((v.y0 + row) * STRIDE + v.x0 + col) % (1 << ADDR_BITS)));
            chk("beat_x", 32'(out_x), 32'((v.x0 + col) % (1 << X_BITS)));
            chk("beat_y", 32'(out_y), 32'((v.y0 + row) % (1 << Y_BITS)));
            chk("beat_last", 32'(out_last), 32'(idx == v.beats - 1));
            chk("busy_in_scan", 32'(busy), 32'd1);
            if (idx == 0) chk("first_addr", 32'(out_addr), 32'(v.first_addr));
            if (idx == v.beats - 1) chk("final_addr", 32'(out_addr), 32'(v.final_addr));
            case (v.mode)
                0: out_ready = 1'b1;
                1: out_ready = (p % 4 == 0) || (p % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            p++;
            if (v.inject && idx == 1 && !injected) begin
                start = 1'b1;
                x0 = 9'd100;
                y0 = 8'd50;
                w  = 9'd7;
                h  = 8'd7;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            xfer = out_ready;
            @(negedge clk);
            guard++;
            if (xfer) idx++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("beat_count", 32'(idx), 32'(v.beats));
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd1);
        chk("end_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("end_done_fall", 32'(done), 32'd0);
        chk("end_busy_fall", 32'(busy), 32'd0);
        if (v.inject) begin
            repeat (3) begin
                @(negedge clk);
                chk("inject_no_valid", 32'(out_valid), 32'd0);
                chk("inject_no_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int lat;
        vecs[0] = '{x0: 1,   y0: 1,   w: 2, h: 2,   beats: 4,   first_addr: 321,   final_addr: 642,   mode: 0, inject: 0};
        vecs[1] = '{x0: 1,   y0: 1,   w: 2, h: 2,   beats: 4,   first_addr: 321,   final_addr: 642,   mode: 1, inject: 0};
        vecs[2] = '{x0: 5,   y0: 0,   w: 0, h: 3,   beats: 0,   first_addr: 0,     final_addr: 0,     mode: 0, inject: 0};
        vecs[3] = '{x0: 0,   y0: 255, w: 1, h: 1,   beats: 1,   first_addr: 81600, final_addr: 81600, mode: 0, inject: 0};
        vecs[4] = '{x0: 318, y0: 2,   w: 4, h: 2,   beats: 8,   first_addr: 958,   final_addr: 1281,  mode: 2, inject: 0};
        vecs[5] = '{x0: 510, y0: 0,   w: 3, h: 1,   beats: 3,   first_addr: 510,   final_addr: 512,   mode: 1, inject: 0};
        vecs[6] = '{x0: 0,   y0: 255, w: 1, h: 255, beats: 255, first_addr: 81600, final_addr: 31808, mode: 2, inject: 0};
        vecs[7] = '{x0: 3,   y0: 7,   w: 4, h: 0,   beats: 0,   first_addr: 0,     final_addr: 0,     mode: 0, inject: 0};

        rst = 1'b1;
        start = 1'b0;
        x0 = '0;
        y0 = '0;
        w = '0;
        h = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // Second start during SCAN must be ignored.
        begin
            vec_t vi;
            vi = vecs[0];
            vi.inject = 1'b1;
            run_cmd(vi);
        end

        // Asynchronous reset in the middle of a scan.
        @(negedge clk);
        x0 = 9'd0;
        y0 = 8'd10;
        w = 9'd5;
        h = 8'd5;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_seq_latency", 32'(lat), 32'(Y_BITS + 1));
        repeat (2) @(negedge clk);
        chk("rst_seq_addr_before", 32'(out_addr), 32'd3202);
        #2 rst = 1'b1;
        #1 chk_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end
        run_cmd(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
